vga_sprite_collision_core: RTL

// - Read-side companion of the sprite layers: snoops two keyed sprite layers per pixel and flags overlap.
// - Per frame: counts overlapping pixels, records the first-hit coordinate, latches results at frame wrap.
// - The MicroBlaze reads results over the slot bus (cs/read/addr -> rd_data); the status read clears the sticky flag.
// - Sits beside the sprite cores; video path is not modified (observe-only).

---
 rtl/vga_sprite_collision_core_pkg.sv | 23 ++
 rtl/vga_sprite_collision_core_if.sv | 17 +
 rtl/vga_sprite_collision_core_pix_align.sv | 59 +++++
 rtl/vga_sprite_collision_core.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/vga_sprite_collision_core_pkg.sv
// Package: vga_coll_pkg
// Shared types and slot-bus register addresses for the sprite collision core.
//   coll_state_t : collision FSM encoding (DISARMED / ARMED / TRIGGERED)
//   REG_*        : decoded values of addr[1:0] for writes (CTRL, CLR) and reads
//                  (STAT, CNT, HIT, FRM)
package vga_coll_pkg;

  typedef enum logic [1:0] {
    DISARMED  = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2
  } coll_state_t;

  // write map
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CLR  = 2'd1;
  // read map
  localparam logic [1:0] REG_STAT = 2'd0;
  localparam logic [1:0] REG_CNT  = 2'd1;
  localparam logic [1:0] REG_HIT  = 2'd2;
  localparam logic [1:0] REG_FRM  = 2'd3;

endpackage

// File: rtl/vga_sprite_collision_core_if.sv
// Interface: vga_sprite_collision_core_if
// Slot bus between the MicroBlaze side (master) and the collision core (slave).
//   cs, read, write : slot select and 1-clk strobes
//   addr            : 14-bit word address (core decodes addr[1:0])
//   wr_data         : write data
//   rd_data         : read data, combinational from addr[1:0]
interface vga_sprite_collision_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/vga_sprite_collision_core_pix_align.sv
// Module: coll_pix_align
// Delays the sync-counter coordinates by PIPE_DLY clocks (0..3) so they line up
// with the sprite layer colour outputs, and detects pixel changes.
//   clk, reset  : clock, asynchronous active-high reset
//   x, y        : raw coordinates (held several clocks per pixel)
//   xd, yd      : delayed coordinates
//   new_pix     : first clock on which (xd,yd) differs from the previous value
//   frame_start : new_pix at (0,0)
module coll_pix_align #(
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic [10:0] xd,
  output logic [10:0] yd,
  output logic        new_pix,
  output logic        frame_start
);

  logic [21:0] s1, s2, s3;
  logic [21:0] cur;
  logic [21:0] prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {x, y};
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Fixed 3-deep line with a tap select; unused stages are trimmed.
  always_comb begin
    case (PIPE_DLY)
      0:       cur = {x, y};
      1:       cur = s1;
      2:       cur = s2;
      default: cur = s3;
    endcase
  end

  // prev resets to an out-of-range coordinate so the first pixel after reset is new.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= '1;
    else       prev <= cur;
  end

  assign xd          = cur[21:11];
  assign yd          = cur[10:0];
  assign new_pix     = (cur != prev);
  assign frame_start = new_pix && (cur == '0);

endmodule

// File: rtl/vga_sprite_collision_core.sv
// Module: vga_sprite_collision_core
// Observe-only collision detector for two keyed sprite layers. Counts pixels
// where both layers are opaque, records the first hit per frame and latches the
// results at frame wrap for the CPU.
//   clk, reset       : clock, asynchronous active-high reset
//   x, y             : pixel coordinates from the sync counter
//   sa_rgb, sb_rgb   : pre-blend sprite layer pixels
//   bus (slave)      : slot bus, see vga_sprite_collision_core_if
//   irq              : sticky & irq_en (only with VGA_COLL_IRQ_EN defined)
// Build option: VGA_COLL_IRQ_EN adds the irq port and ctrl bit2 (irq_en).
module vga_sprite_collision_core
  import vga_coll_pkg::*;
#(
  parameter int              CD        = 12,
  parameter logic [CD-1:0]   KEY_COLOR = '0,
  parameter int              HRES      = 640,
  parameter int              VRES      = 480,
  parameter int unsigned     PIPE_DLY  = 1,
  parameter int              CNT_W     = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic [CD-1:0] sa_rgb,
  input  logic [CD-1:0] sb_rgb,
`ifdef VGA_COLL_IRQ_EN
  output logic          irq,
`endif
  vga_sprite_collision_core_if.slave bus
);

  localparam logic [11:0] HRES_L = 12'(HRES);
  localparam logic [11:0] VRES_L = 12'(VRES);

  logic [10:0]      xd, yd;
  logic             new_pix, frame_start;
  logic             ctrl_wr, clr_wr, stat_rd, hit, latch;

  coll_state_t      state;
  logic             oneshot;
  logic [CNT_W-1:0] acc_cnt, last_count;
  logic [10:0]      acc_x, acc_y, first_x, first_y;
  logic             acc_hv, hit_valid, frame_valid, sticky;
  logic [15:0]      frame_cnt;

  coll_pix_align #(.PIPE_DLY(PIPE_DLY)) u_align (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .xd          (xd),
    .yd          (yd),
    .new_pix     (new_pix),
    .frame_start (frame_start)
  );

  always_comb begin
    ctrl_wr = bus.cs && bus.write && (bus.addr[1:0] == REG_CTRL);
    clr_wr  = bus.cs && bus.write && (bus.addr[1:0] == REG_CLR);
    stat_rd = bus.cs && bus.read  && (bus.addr[1:0] == REG_STAT);
    hit     = new_pix && ({1'b0, xd} < HRES_L) && ({1'b0, yd} < VRES_L) &&
              (sa_rgb != KEY_COLOR) && (sb_rgb != KEY_COLOR);
    // Latch decision uses the pre-write state so a same-cycle ctrl write cannot cancel it.
    latch   = (state == ARMED) && frame_start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= DISARMED;
      oneshot     <= 1'b0;
      acc_cnt     <= '0;
      acc_x       <= '0;
      acc_y       <= '0;
      acc_hv      <= 1'b0;
      last_count  <= '0;
      first_x     <= '0;
      first_y     <= '0;
      hit_valid   <= 1'b0;
      frame_valid <= 1'b0;
      sticky      <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (ctrl_wr)
        state <= bus.wr_data[0] ? ARMED : DISARMED;
      else if (clr_wr && state == TRIGGERED)
        state <= ARMED;
      else if (latch && acc_hv && oneshot)
        state <= TRIGGERED;

      if (ctrl_wr) oneshot <= bus.wr_data[1];

      if (state != ARMED) begin
        acc_cnt <= '0;
        acc_x   <= '0;
        acc_y   <= '0;
        acc_hv  <= 1'b0;
      end else if (frame_start) begin
        // The (0,0) pixel opens the new frame's accumulation.
        acc_cnt <= CNT_W'(hit);
        acc_hv  <= hit;
        acc_x   <= hit ? xd : '0;
        acc_y   <= hit ? yd : '0;
      end else if (hit) begin
        if (acc_cnt != '1) acc_cnt <= acc_cnt + CNT_W'(1);
        if (!acc_hv) begin
          acc_hv <= 1'b1;
          acc_x  <= xd;
          acc_y  <= yd;
        end
      end

      if (latch) begin
        last_count <= acc_cnt;
        first_x    <= acc_x;
        first_y    <= acc_y;
        hit_valid  <= acc_hv;
        frame_cnt  <= frame_cnt + 16'd1;
      end

      if (latch)       frame_valid <= 1'b1;
      else if (clr_wr) frame_valid <= 1'b0;

      // A same-cycle set beats the read/write clear.
      if (latch && acc_cnt != '0)   sticky <= 1'b1;
      else if (stat_rd || clr_wr)   sticky <= 1'b0;
    end
  end

`ifdef VGA_COLL_IRQ_EN
  logic irq_en;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        irq_en <= 1'b0;
    else if (ctrl_wr) irq_en <= bus.wr_data[2];
  end
  assign irq = sticky & irq_en;
  logic unused_bits;
  assign unused_bits = ^{bus.addr[13:2], bus.wr_data[31:3]};
`else
  logic unused_bits;
  assign unused_bits = ^{bus.addr[13:2], bus.wr_data[31:2]};
`endif

  always_comb begin
    bus.rd_data = '0;
    case (bus.addr[1:0])
      REG_STAT: bus.rd_data = {28'd0, state, frame_valid, sticky};
      REG_CNT:  bus.rd_data = 32'(last_count);
      REG_HIT:  bus.rd_data = {hit_valid, 4'd0, first_y, 5'd0, first_x};
      REG_FRM:  bus.rd_data = {16'd0, frame_cnt};
      default:  bus.rd_data = '0;
    endcase
  end

endmodule
